// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_pkg                                                      |
// | Description : Shared defaults, reader state encoding and bit reversal for  |
// |               the FFT bit-reversal reorder stage.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int DEFAULT_DATA_NUM   = 1024;
    localparam int DEFAULT_ADDR_WIDTH = 10;
    localparam int DEFAULT_DATA_WIDTH = 64;

    // Widest address the generic bit-reversal helper supports.
    localparam int BITREV_MAX_W = 16;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_READ = 1'b1
    } rd_state_t;

    // Reverses the low 'width' bits of addr; bits at and above 'width' return 0.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] addr,
        input int                      width
    );
        logic [BITREV_MAX_W-1:0] rev;
        rev = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < width) begin
                rev[i] = addr[width-1-i];
            end
        end
        return rev;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reorder_sdp_ram                                              |
// | Description : Simple dual-port RAM with registered read, one write port    |
// |               and one read port, shaped to infer block RAM.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reorder_sdp_ram #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // No reset on the array or read register so the tools can map to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_bitrev_reorder                                           |
// | Description : Ping-pong reorder of bit-reversed FFT frames into natural    |
// |               bin order. Define REORDER_FRAME_MARK_EN to add the           |
// |               data_o_sof / data_o_eof frame markers.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int DATA_NUM   = DEFAULT_DATA_NUM,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  data_i_en,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  data_o_en,
    output logic [DATA_WIDTH-1:0] data_o,
`ifdef REORDER_FRAME_MARK_EN
    output logic                  data_o_sof,
    output logic                  data_o_eof,
`endif
    output logic                  busy_o
);

    localparam logic [ADDR_WIDTH-1:0] c_last = ADDR_WIDTH'(DATA_NUM - 1);

    logic [ADDR_WIDTH-1:0] r_wr_cnt;
    logic                  r_wr_bank;
    logic                  r_drop;
    logic [1:0]            r_full;
    logic                  w_drop;
    logic                  w_wr_en;
    logic                  w_wr_last;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [1:0]            w_wr_set;

    rd_state_t             r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_cnt, w_rd_cnt_nxt;
    logic                  r_rd_bank, w_rd_bank_nxt;
    logic                  w_rd_en;
    logic                  w_rd_bank;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [1:0]            w_rd_clr;

    logic [DATA_WIDTH-1:0] w_ram_q;
    logic                  r_q_vld;
    logic                  r_data_o_en;
    logic [DATA_WIDTH-1:0] r_data_o;

    // Drop decision is taken on the first sample and held for the whole frame.
    assign w_drop    = (r_wr_cnt == '0) ? r_full[r_wr_bank] : r_drop;
    assign w_wr_en   = data_i_en & ~w_drop;
    assign w_wr_last = data_i_en & (r_wr_cnt == c_last);
    assign w_wr_set  = (w_wr_last & ~w_drop) ? {r_wr_bank, ~r_wr_bank} : 2'b00;
    assign w_wr_addr = ADDR_WIDTH'(bitrev(BITREV_MAX_W'(r_wr_cnt), ADDR_WIDTH));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_drop    <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            if (data_i_en) begin
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + ADDR_WIDTH'(1);
                r_drop   <= w_drop;
                // A discarded frame leaves the writer on the same bank.
                if (w_wr_last && !w_drop) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            r_full <= (r_full & ~w_rd_clr) | w_wr_set;
        end
    end

    // Address 0 is issued in the same cycle IDLE sees a full bank.
    always_comb begin
        w_state_nxt   = r_state;
        w_rd_cnt_nxt  = r_rd_cnt;
        w_rd_bank_nxt = r_rd_bank;
        w_rd_en       = 1'b0;
        w_rd_bank     = r_rd_bank;
        w_rd_addr     = r_rd_cnt;
        w_rd_clr      = 2'b00;
        case (r_state)
            RD_IDLE: begin
                if (|r_full) begin
                    w_rd_en       = 1'b1;
                    w_rd_bank     = ~r_full[0];
                    w_rd_addr     = '0;
                    w_state_nxt   = RD_READ;
                    w_rd_bank_nxt = ~r_full[0];
                    w_rd_cnt_nxt  = ADDR_WIDTH'(1);
                end
            end
            RD_READ: begin
                w_rd_en = 1'b1;
                if (r_rd_cnt == c_last) begin
                    w_rd_clr     = {r_rd_bank, ~r_rd_bank};
                    w_rd_cnt_nxt = '0;
                    if (r_full[~r_rd_bank]) begin
                        w_rd_bank_nxt = ~r_rd_bank;
                    end else begin
                        w_state_nxt = RD_IDLE;
                    end
                end else begin
                    w_rd_cnt_nxt = r_rd_cnt + ADDR_WIDTH'(1);
                end
            end
            default: w_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= RD_IDLE;
            r_rd_cnt  <= '0;
            r_rd_bank <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_cnt  <= w_rd_cnt_nxt;
            r_rd_bank <= w_rd_bank_nxt;
        end
    end

    reorder_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH + 1),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_addr ({r_wr_bank, w_wr_addr}),
        .wr_data (data_i),
        .rd_en   (w_rd_en),
        .rd_addr ({w_rd_bank, w_rd_addr}),
        .rd_data (w_ram_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q_vld     <= 1'b0;
            r_data_o_en <= 1'b0;
            r_data_o    <= '0;
        end else begin
            r_q_vld     <= w_rd_en;
            r_data_o_en <= r_q_vld;
            if (r_q_vld) begin
                r_data_o <= w_ram_q;
            end
        end
    end

`ifdef REORDER_FRAME_MARK_EN
    logic r_q_sof, r_q_eof;
    logic r_sof, r_eof;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q_sof <= 1'b0;
            r_q_eof <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            r_q_sof <= w_rd_en & (w_rd_addr == '0);
            r_q_eof <= w_rd_en & (w_rd_addr == c_last);
            r_sof   <= r_q_sof;
            r_eof   <= r_q_eof;
        end
    end

    assign data_o_sof = r_sof;
    assign data_o_eof = r_eof;
`endif

    assign data_o_en = r_data_o_en;
    assign data_o    = r_data_o;
    assign busy_o    = (r_wr_cnt != '0) | (|r_full) | (r_state == RD_READ);

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_bitrev_reorder                                        |
// | Description : Directed self-checking bench for fft_bitrev_reorder with a   |
// |               frame-level scoreboard (natural index n <- arrival bitrev(n))|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_bitrev_reorder;

    localparam int N = 1024;

    logic        clk;
    logic        rstn;
    logic        data_i_en;
    logic [63:0] data_i;
    logic        data_o_en;
    logic [63:0] data_o;
    logic        busy_o;
`ifdef REORDER_FRAME_MARK_EN
    logic        data_o_sof;
    logic        data_o_eof;
`endif

    fft_bitrev_reorder dut (
        .clk       (clk),
        .rstn      (rstn),
        .data_i_en (data_i_en),
        .data_i    (data_i),
        .data_o_en (data_o_en),
        .data_o    (data_o),
`ifdef REORDER_FRAME_MARK_EN
        .data_o_sof(data_o_sof),
        .data_o_eof(data_o_eof),
`endif
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] exp_q[$];
    logic [63:0] cap [0:N-1];
    logic [63:0] cap_ref [0:N-1];
    int beat_idx    = 0;
    int run_len     = 0;
    int max_run     = 0;
    int beats_total = 0;
    int first_cyc   = 0;

    // Plain arithmetic 10-bit reversal for the model.
    function automatic int rev10(input int x);
        int r = 0;
        for (int b = 0; b < 10; b++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            beat_idx = 0;
            run_len  = 0;
        end else if (data_o_en) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data_o=%h with no frame expected (cyc %0d)", data_o, cyc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (data_o !== e) begin
                    n_fail++;
                    $display("FAIL data beat %0d: got %h want %h (cyc %0d)", beat_idx, data_o, e, cyc);
                end
            end
`ifdef REORDER_FRAME_MARK_EN
            n_tests++;
            if (data_o_sof !== (beat_idx == 0) || data_o_eof !== (beat_idx == N-1)) begin
                n_fail++;
                $display("FAIL marks beat %0d: got sof=%b eof=%b want sof=%b eof=%b",
                         beat_idx, data_o_sof, data_o_eof, beat_idx == 0, beat_idx == N-1);
            end
`endif
            if (beat_idx == 0) first_cyc = cyc;
            cap[beat_idx] = data_o;
            beat_idx = (beat_idx + 1) % N;
            run_len++;
            if (run_len > max_run) max_run = run_len;
            beats_total++;
        end else begin
            if (beat_idx != 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL bubble: data_o_en low at beat %0d of frame (cyc %0d)", beat_idx, cyc);
                beat_idx = 0;
            end
`ifdef REORDER_FRAME_MARK_EN
            n_tests++;
            if (data_o_sof !== 1'b0 || data_o_eof !== 1'b0) begin
                n_fail++;
                $display("FAIL marks_idle: got sof=%b eof=%b want 0 0", data_o_sof, data_o_eof);
            end
`endif
            run_len = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // pat 0: real=k, imag=-k; pat>0: tagged real, random imag. stop_at>=0 aborts mid-frame.
    task automatic send_frame(input int pat, input int gap_pct, input int stop_at, output int t_last);
        logic [63:0] arr [0:N-1];
        for (int k = 0; k < N; k++) begin
            logic [31:0] re, im;
            re = (pat == 0) ? 32'(k) : 32'(pat * 100000 + k);
            im = (pat == 0) ? 32'(-k) : 32'($urandom);
            arr[k] = {re, im};
        end
        t_last = 0;
        for (int k = 0; k < N; k++) begin
            if (k == stop_at) return;
            while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
                @(posedge clk);
                #1;
            end
            data_i_en = 1'b1;
            data_i    = arr[k];
            @(posedge clk);
            #1;
            data_i_en = 1'b0;
            t_last    = cyc;
        end
        for (int n = 0; n < N; n++) exp_q.push_back(arr[rev10(n)]);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || data_o_en) && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_tests++;
        if (n >= 4000) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d beats still pending after %0d cycles, want 0", name, exp_q.size(), n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_last, b0, mism;
        rstn      = 1'b0;
        data_i_en = 1'b0;
        data_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy_o, data_o_en, 62'(data_o)}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("idle", {busy_o, data_o_en, 62'(0)} | 64'(data_o != 0), 64'd0);
        end

        // Single contiguous frame with hand-known values.
        b0 = beats_total;
        send_frame(0, 0, -1, t_last);
        check("busy_after_frame", 64'(busy_o), 64'd1);
        wait_drain("frame1");
        check("latency", 64'(first_cyc - t_last), 64'd2);
        check("beats_frame1", 64'(beats_total - b0), 64'(N));
        check("n0",    cap[0],    {32'd0,    32'h0000_0000});
        check("n1",    cap[1],    {32'd512,  32'hFFFF_FE00});
        check("n2",    cap[2],    {32'd256,  32'hFFFF_FF00});
        check("n3",    cap[3],    {32'd768,  32'hFFFF_FD00});
        check("n1023", cap[1023], {32'd1023, 32'hFFFF_FC01});
        check("hold",  data_o,    {32'd1023, 32'hFFFF_FC01});
        check("busy_idle", 64'(busy_o), 64'd0);
        for (int i = 0; i < N; i++) cap_ref[i] = cap[i];

        // Three frames back to back.
        b0 = beats_total;
        max_run = 0;
        send_frame(1, 0, -1, t_last);
        send_frame(2, 0, -1, t_last);
        send_frame(3, 0, -1, t_last);
        wait_drain("b2b");
        check("beats_b2b", 64'(beats_total - b0), 64'(3 * N));
        check("run_b2b", 64'(max_run), 64'(3 * N));

        // Same data as the first frame, with ~30% input gaps.
        b0 = beats_total;
        max_run = 0;
        send_frame(0, 30, -1, t_last);
        wait_drain("gaps");
        mism = 0;
        for (int i = 0; i < N; i++) if (cap[i] !== cap_ref[i]) mism++;
        check("gaps_vs_nogap_mismatches", 64'(mism), 64'd0);
        check("run_gaps", 64'(max_run), 64'(N));

        // Reset in the middle of a frame, then a clean frame.
        b0 = beats_total;
        send_frame(4, 0, 500, t_last);
        @(negedge clk);
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_out", {busy_o, data_o_en, 62'(0)}, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        send_frame(5, 0, -1, t_last);
        wait_drain("after_reset");
        check("beats_after_reset", 64'(beats_total - b0), 64'(N));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
